// File: rtl/sequential_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_t   : FSM state encoding (2 bits) for IDLE / RUN / DONE.
//   cnt_width : bit width of the digit counter, $clog2(WIDTH/DIGIT) with a floor of 1.
package sequential_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width, input int digit);
    int n;
    if (digit < 1) return 1;
    n = width / digit;
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sequential_adder_if.sv
// Operand / result bus of the digit-serial adder.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
//   Status     : busy
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds its payload stable while valid is high and ready
// is low; ready may be asserted independently of valid.
// master = producer of operands / consumer of results, slave = the adder.
interface sequential_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/sequential_adder_digit_adder.sv
// Combinational DIGIT-bit adder slice.
//   x, y  : digit operands
//   ci    : carry in
//   s     : digit sum
//   co    : carry out of the digit's top bit
//   c_msb : carry into the digit's top bit (for signed overflow detection)
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] full;

  always_comb begin
    full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    s     = full[DIGIT-1:0];
    co    = full[DIGIT];
    // Sum bit = x ^ y ^ carry_in, so the carry into the top bit is recovered
    // from the top sum bit; this also covers DIGIT == 1 (c_msb == ci).
    c_msb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
  end
endmodule

// File: rtl/sequential_adder.sv
// Digit-serial adder/subtractor: sums DIGIT bits per clock, WIDTH/DIGIT cycles
// per operation.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : operand/result handshake bus (slave side)
//   dbg_state : current FSM state
module sequential_adder
  import sequential_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  sequential_adder_if.slave   bus,
  output state_t              dbg_state
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("sequential_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co, dig_c_msb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_c_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + ~cin: invert B and the carry-in once here.
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_co;
        // New digit enters at the MSB end; after N digits the LSB digit has
        // been shifted down to bit 0.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = dig_co;
          ovf_d   = dig_c_msb ^ dig_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;
endmodule

// File: doc/sequential_adder.md
SEQUENTIAL_ADDER -- requirements
Module: sequential_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, bits summed per clock cycle; WIDTH % DIGIT == 0 and 1 <= DIGIT <= WIDTH, otherwise elaboration error.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand set a/b/cin/sub presented.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in (add) or borrow-in (sub).
REQ-011 sub  input  1  0 = A+B+cin, 1 = A-B-cin.
REQ-012 out_valid  output  1  result fields valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-015 cout  output  1  carry-out; in sub mode 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-019 IDLE: on in_valid&&in_ready, capture a, b XOR {WIDTH{sub}}, carry = cin XOR sub, clear digit counter, go to RUN.
REQ-020 RUN: each cycle add lowest DIGIT bits of the operand registers plus carry, shift result digit into sum from MSB side, shift operands right by DIGIT, update carry, increment counter.
REQ-021 After exactly N = WIDTH/DIGIT RUN cycles the FSM SHALL enter DONE; out_valid rises N cycles after the accepting edge.
REQ-022 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered on the final RUN cycle.
REQ-023 DONE: sum/cout/ovf SHALL hold stable while out_valid&&!out_ready; on out_ready go to IDLE.
REQ-024 in_valid during RUN/DONE SHALL be ignored (no queueing); inputs need only be stable on the accepting edge.
REQ-025 out_ready while not DONE SHALL have no effect.
REQ-026 Maximum throughput SHALL be one result per N+2 cycles (accept, N RUN, DONE with out_ready high).
REQ-027 sum/cout/ovf SHALL retain last result after leaving DONE until next RUN overwrites sum.

Reset
REQ-028 rst SHALL asynchronously force IDLE; sum, cout, ovf, counter, operand and carry registers to 0; in_ready=1, out_valid=0, busy=0.
REQ-029 rst during RUN or DONE SHALL abort the operation; no out_valid is produced for it.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (2-bit encoding) and the DIGIT-count width function ($clog2(WIDTH/DIGIT) floor 1).
REQ-031 One combinational sub-module digit_adder (parameter DIGIT; inputs x, y, ci; outputs s, co, c_msb) SHALL perform the per-cycle digit sum; c_msb is the carry into the digit's top bit, used for ovf.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-032 a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid 4 cycles after accept, sum=0x5555, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-034 sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-035 out_ready low 3 cycles in DONE -> sum/cout/ovf unchanged, in_ready=0; second in_valid during RUN ignored.
REQ-036 rst asserted mid-RUN (cycle 2) -> immediate in_ready=1, sum=0, no out_valid; next operation completes correctly.
REQ-037 DIGIT=1 and DIGIT=16 builds: 0xA5A5+0x5A5A+cin=1 -> sum=0x0000, cout=1, latency 16 and 1 respectively.
